sync_fifo_v2: RTL and testbench
===============================

# sync_fifo_v2

Parametrised successor to the team's single-clock synchronous FIFO. It supports arbitrary (non-power-of-two) depth, configurable data width, programmable almost-full/almost-empty levels, an occupancy output and a registered read-valid strobe. An optional synchronous flush can be compiled in. It sits between any producer/consumer pair in the same clock domain and keeps the existing handshake semantics (`wr_ack`, `overflow`, `underflow`, `full`, `empty`, `almostfull`, `almostempty`), so existing environments port over with minimal change.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: width of the write and read data.
- `FIFO_DEPTH`, default 8: number of entries. Any value ≥ 2 is legal; it need not be a power of two.
- `AF_LEVEL`, default `FIFO_DEPTH-1`: `almostfull` threshold. Legal range is 1..`FIFO_DEPTH-1`.
- `AE_LEVEL`, default 1: `almostempty` threshold. Legal range is 1..`FIFO_DEPTH-1`.
- `CW`, derived as `$clog2(FIFO_DEPTH+1)`: width of `count`.

Ports:
- `clk` in 1: the only clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: write request.
- `rd_en` in 1: read request.
- `data_in` in `DATA_WIDTH`: write data.
- `flush` in 1: synchronous flush. Present only with `SYNC_FIFO_FLUSH_EN`.
- `data_out` out `DATA_WIDTH`: registered read data.
- `rd_valid` out 1: `data_out` was updated by a read accepted on the previous edge.
- `wr_ack` out 1: registered; a write was accepted on the previous edge.
- `overflow` out 1: registered; a write was rejected on the previous edge.
- `underflow` out 1: registered; a read was rejected on the previous edge.
- `full`, `empty`, `almostfull`, `almostempty` out 1 each: combinational from `count`.
- `count` out `CW`: current occupancy, 0..`FIFO_DEPTH`.

## Operation
- Storage is `FIFO_DEPTH` x `DATA_WIDTH` memory with a write pointer `wr_ptr` and a read pointer `rd_ptr`.
  - Each pointer increments by 1 and wraps from `FIFO_DEPTH-1` to 0 by explicit compare, not by overflow.
- Accept rules, evaluated each edge:
  - A write is accepted iff `wr_en && !full`.
  - A read is accepted iff `rd_en && !empty`.
  - `wr_en && rd_en` while full: only the read is accepted; `count` decrements by 1 and `overflow` is set next cycle.
  - `wr_en && rd_en` while empty: only the write is accepted; `count` increments by 1 and `underflow` is set next cycle.
  - `wr_en && rd_en` otherwise: both are accepted; `count` is unchanged and both pointers advance.
- Status flags:
  - `full` = (`count == FIFO_DEPTH`).
  - `empty` = (`count == 0`).
  - `almostfull` = (`count >= AF_LEVEL && !full`).
  - `almostempty` = (`count <= AE_LEVEL && !empty`).
- `wr_ack`, `overflow`, `underflow` and `rd_valid` are single-cycle pulses reflecting the previous edge's decision. They are 0 otherwise.
- `data_out` holds its last value when no read is accepted.
- Reset (`rst_n` low) forces all of the following immediately, regardless of `clk`:
  - `wr_ptr`, `rd_ptr` and `count` to 0.
  - `data_out` to 0.
  - `wr_ack`, `overflow`, `underflow` and `rd_valid` to 0.
  - Flags therefore read `empty`=1, `full`=0, `almostfull`=0, `almostempty`=0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all stored entries. The first edge after deassertion behaves as for an empty FIFO.

## Timing
- Write-to-read latency:
  - Data written at edge N is readable at edge N+1 (`empty` drops after N).
  - A read accepted at edge M presents data on `data_out` with `rd_valid`=1 after M.
- `count` and the flags update in the same cycle as the accepting edge; there is no extra flag latency.
- Sustained throughput is one write and one read per cycle.
- Pointer wrap must not create a bubble. `wr_ptr` = `FIFO_DEPTH-1` with an accepted write goes to 0 on the next edge.

## Configuration
- `SYNC_FIFO_FLUSH_EN` defined:
  - The `flush` port exists.
  - `flush`=1 at an edge sets pointers and `count` to 0 and clears `wr_ack`, `overflow`, `underflow` and `rd_valid`.
  - `flush` has priority over `wr_en` and `rd_en` in the same cycle; neither request is accepted and no error pulse is raised.
  - `data_out` holds its value.
- Not defined: the port is absent and behaviour is identical to `flush` tied to 0.

## Test plan
- Reset then idle: all outputs 0 except `empty`=1. Then `rd_en`=1 for one cycle gives `underflow`=1 for exactly one cycle and `count` stays 0.
- Default parameters, 8 writes of 0x0001..0x0008: `wr_ack` pulses 8 times, `almostfull` is high at `count`=7, `full` is high at 8. A 9th write gives `overflow`=1 and `count` stays 8.
- `FIFO_DEPTH`=5: 5 writes, 3 reads, 3 writes, 5 reads. `data_out` order must be the exact write order across the wrap, and `count` ends at 0.
- Full with `wr_en`=`rd_en`=1: `count` goes 8→7 and `overflow`=1. Empty with both high: `count` goes 0→1 and `underflow`=1.
- `AF_LEVEL`=5, `AE_LEVEL`=2, `FIFO_DEPTH`=8: `almostempty` is high for `count` 1..2; `almostfull` is high for `count` 5..7.
- With `SYNC_FIFO_FLUSH_EN`, fill 4 entries, then assert `flush` together with `wr_en`: next cycle `count`=0, `empty`=1, `wr_ack`=0 and `data_out` is unchanged.

Source files
------------

// File: rtl/sync_fifo_v2.sv
// ============================================================================
// Module   : sync_fifo_v2
// Brief    : Single-clock FIFO, any depth >= 2, registered read data and
//            handshake pulses. SYNC_FIFO_FLUSH_EN adds a synchronous flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_v2 #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
`ifdef SYNC_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);

    localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] c_last = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] c_depth = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_af    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] c_ae    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_flush;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

`ifdef SYNC_FIFO_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    // Flush suppresses both requests so nothing is written or counted.
    assign w_wr_acc = wr_en && !w_full  && !w_flush;
    assign w_rd_acc = rd_en && !w_empty && !w_flush;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en && !w_wr_acc;
            r_underflow <= rd_en && !w_rd_acc;
            r_rd_valid  <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign rd_valid    = r_rd_valid;
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= c_af) && !w_full;
    assign almostempty = (r_count <= c_ae) && !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_v2.sv
// ============================================================================
// Module   : tb_sync_fifo_v2
// Brief    : Directed bench for sync_fifo_v2 (default, depth-5 and custom
//            threshold instances); flush steps build with SYNC_FIFO_FLUSH_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_v2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        a_wr, a_rd, a_fl;
    logic [15:0] a_din, a_dout;
    logic        a_rv, a_ack, a_ov, a_un, a_full, a_empty, a_af, a_ae;
    logic [3:0]  a_cnt;
    // Instance B: FIFO_DEPTH = 5
    logic        b_wr, b_rd, b_fl;
    logic [15:0] b_din, b_dout;
    logic        b_rv, b_ack, b_ov, b_un, b_full, b_empty, b_af, b_ae;
    logic [2:0]  b_cnt;
    // Instance C: AF_LEVEL = 5, AE_LEVEL = 2
    logic        c_wr, c_rd, c_fl;
    logic [15:0] c_din, c_dout;
    logic        c_rv, c_ack, c_ov, c_un, c_full, c_empty, c_af, c_ae;
    logic [3:0]  c_cnt;

    sync_fifo_v2 u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_wr), .rd_en(a_rd), .data_in(a_din),
`ifdef SYNC_FIFO_FLUSH_EN
        .flush(a_fl),
`endif
        .data_out(a_dout), .rd_valid(a_rv), .wr_ack(a_ack), .overflow(a_ov),
        .underflow(a_un), .full(a_full), .empty(a_empty), .almostfull(a_af),
        .almostempty(a_ae), .count(a_cnt)
    );

    sync_fifo_v2 #(.FIFO_DEPTH(5)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr), .rd_en(b_rd), .data_in(b_din),
`ifdef SYNC_FIFO_FLUSH_EN
        .flush(b_fl),
`endif
        .data_out(b_dout), .rd_valid(b_rv), .wr_ack(b_ack), .overflow(b_ov),
        .underflow(b_un), .full(b_full), .empty(b_empty), .almostfull(b_af),
        .almostempty(b_ae), .count(b_cnt)
    );

    sync_fifo_v2 #(.FIFO_DEPTH(8), .AF_LEVEL(5), .AE_LEVEL(2)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(c_wr), .rd_en(c_rd), .data_in(c_din),
`ifdef SYNC_FIFO_FLUSH_EN
        .flush(c_fl),
`endif
        .data_out(c_dout), .rd_valid(c_rv), .wr_ack(c_ack), .overflow(c_ov),
        .underflow(c_un), .full(c_full), .empty(c_empty), .almostfull(c_af),
        .almostempty(c_ae), .count(c_cnt)
    );

    int total = 0;
    int bad   = 0;
    int acks  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_wr = 0; a_rd = 0; a_fl = 0; a_din = '0;
        b_wr = 0; b_rd = 0; b_fl = 0; b_din = '0;
        c_wr = 0; c_rd = 0; c_fl = 0; c_din = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        // Reset acts without a clock edge
        chk("rst_empty", a_empty, 1);
        chk("rst_full",  a_full, 0);
        chk("rst_af",    a_af, 0);
        chk("rst_ae",    a_ae, 0);
        chk("rst_count", a_cnt, 0);
        chk("rst_dout",  a_dout, 0);
        chk("rst_pulses", {a_ack, a_ov, a_un, a_rv}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Read while empty
        a_rd = 1; tick(); a_rd = 0;
        chk("uf_pulse", a_un, 1);
        chk("uf_count", a_cnt, 0);
        tick();
        chk("uf_clear", a_un, 0);

        // Fill default instance
        for (int i = 1; i <= 8; i++) begin
            a_wr = 1; a_din = 16'(i);
            tick();
            acks += a_ack;
            chk("fill_count", a_cnt, i);
            chk("fill_af",    a_af, (i == 7));
            chk("fill_full",  a_full, (i == 8));
        end
        chk("fill_acks", acks, 8);
        a_din = 16'h0009; tick();
        chk("ovf_pulse", a_ov, 1);
        chk("ovf_ack",   a_ack, 0);
        chk("ovf_count", a_cnt, 8);

        // Full with write and read: only the read goes
        a_rd = 1; tick();
        chk("fullrw_count", a_cnt, 7);
        chk("fullrw_ovf",   a_ov, 1);
        chk("fullrw_rv",    a_rv, 1);
        chk("fullrw_dout",  a_dout, 16'h0001);
        a_wr = 0;
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("drain_dout",  a_dout, 16'(i));
            chk("drain_count", a_cnt, 8 - i);
        end

        // Empty with write and read: only the write goes
        a_wr = 1; a_din = 16'h00AA; tick();
        chk("emptyrw_count", a_cnt, 1);
        chk("emptyrw_uf",    a_un, 1);
        chk("emptyrw_ack",   a_ack, 1);
        chk("emptyrw_rv",    a_rv, 0);
        a_wr = 0; tick();
        chk("rd_aa_dout", a_dout, 16'h00AA);
        chk("rd_aa_rv",   a_rv, 1);
        a_rd = 0; tick();
        chk("hold_rv",   a_rv, 0);
        chk("hold_dout", a_dout, 16'h00AA);

`ifdef SYNC_FIFO_FLUSH_EN
        for (int i = 1; i <= 4; i++) begin
            a_wr = 1; a_din = 16'(16'h0100 + i); tick();
        end
        chk("pre_flush_count", a_cnt, 4);
        a_fl = 1; a_din = 16'hBEEF; tick();
        a_fl = 0; a_wr = 0;
        chk("flush_count", a_cnt, 0);
        chk("flush_empty", a_empty, 1);
        chk("flush_ack",   a_ack, 0);
        chk("flush_ovf",   a_ov, 0);
        chk("flush_dout",  a_dout, 16'h00AA);
`endif

        // Depth 5 across the pointer wrap
        for (int j = 1; j <= 5; j++) begin
            b_wr = 1; b_din = 16'(16'h0010 + j); tick();
            chk("b_fill_count", b_cnt, j);
        end
        b_wr = 0;
        chk("b_full", b_full, 1);
        for (int k = 1; k <= 3; k++) begin
            b_rd = 1; tick();
            chk("b_rd1_dout", b_dout, 16'(16'h0010 + k));
        end
        b_rd = 0;
        chk("b_mid_count", b_cnt, 2);
        for (int j = 6; j <= 8; j++) begin
            b_wr = 1; b_din = 16'(16'h0010 + j); tick();
        end
        b_wr = 0;
        chk("b_refull", b_full, 1);
        for (int k = 4; k <= 8; k++) begin
            b_rd = 1; tick();
            chk("b_rd2_dout", b_dout, 16'(16'h0010 + k));
            chk("b_rd2_rv",   b_rv, 1);
        end
        b_rd = 0;
        chk("b_end_count", b_cnt, 0);
        chk("b_end_empty", b_empty, 1);

        // Custom thresholds, filling then draining
        for (int i = 1; i <= 8; i++) begin
            c_wr = 1; c_din = 16'(i); tick();
            chk("c_up_ae", c_ae, (i <= 2));
            chk("c_up_af", c_af, (i >= 5 && i <= 7));
        end
        c_wr = 0;
        for (int i = 7; i >= 0; i--) begin
            c_rd = 1; tick();
            chk("c_dn_count", c_cnt, i);
            chk("c_dn_ae", c_ae, (i >= 1 && i <= 2));
            chk("c_dn_af", c_af, (i >= 5 && i <= 7));
        end
        c_rd = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
